pong_ball_motion: RTL and testbench



---
 rtl/pong_ball_motion.sv | 180 ++++++++++++++++++
 tb/tb_pong_ball_motion.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_motion.sv
// Pong ball-motion controller: serve, flight, wall bounce, paddle hits,
// scoring pulses and per-hit speed-up of the step interval.
module pong_ball_motion #(
    parameter int          SCREEN_W       = 1024,
    parameter int          SCREEN_H       = 768,
    parameter int          BALL_SIZE      = 16,
    parameter int          PAD_W          = 16,
    parameter int          PAD_H          = 96,
    parameter int          PAD_L_X        = 16,
    parameter int          PAD_R_X        = 992,
    parameter logic [19:0] INTERVAL_START = 20'h80000,
    parameter logic [19:0] INTERVAL_MIN   = 20'h00800,
    parameter int          SPEED_SHIFT    = 3
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        serve,
    input  logic        serve_dir,
    input  logic [11:0] serve_ypos,
    input  logic        abort,
    input  logic [11:0] pad_l_ypos,
    input  logic [11:0] pad_r_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        moving,
    output logic        score_l,
    output logic        score_r,
    output logic [3:0]  speed_level
);

    localparam logic [11:0] X_MID  = 12'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [11:0] X_MAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic [11:0] Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [11:0] X_LHIT = 12'(PAD_L_X + PAD_W);
    localparam logic [11:0] X_RHIT = 12'(PAD_R_X - BALL_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVING = 2'd1
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    logic        dx_q, dx_d;
    logic        dy_q, dy_d;
    logic [19:0] count_q, count_d;
    logic [19:0] interval_q, interval_d;
    logic [3:0]  speed_q, speed_d;
    logic        score_l_q, score_l_d;
    logic        score_r_q, score_r_d;

    logic        dx_n, dy_n, hit, miss;
    logic        ovl_l, ovl_r;
    logic [11:0] park_y;
    logic [19:0] ival_dec;

    assign park_y   = (serve_ypos > Y_MAX) ? Y_MAX : serve_ypos;
    assign ival_dec = interval_q - (interval_q >> SPEED_SHIFT);

    assign ovl_l = (({1'b0, ypos_q} + 13'(BALL_SIZE)) > {1'b0, pad_l_ypos})
                && ({1'b0, ypos_q} < ({1'b0, pad_l_ypos} + 13'(PAD_H)));
    assign ovl_r = (({1'b0, ypos_q} + 13'(BALL_SIZE)) > {1'b0, pad_r_ypos})
                && ({1'b0, ypos_q} < ({1'b0, pad_r_ypos} + 13'(PAD_H)));

    // Next-state: park/serve in IDLE, tick counting and step evaluation in flight
    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        count_d    = count_q;
        interval_d = interval_q;
        speed_d    = speed_q;
        score_l_d  = 1'b0;
        score_r_d  = 1'b0;
        dx_n       = dx_q;
        dy_n       = dy_q;
        hit        = 1'b0;
        miss       = 1'b0;
        case (state_q)
            S_MOVING: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (count_q != interval_q) begin
                    count_d = count_q + 20'd1;
                end else begin
                    count_d = '0;
                    if (!dy_q && ypos_q == '0) begin
                        dy_n = 1'b1;
                    end else if (dy_q && ypos_q == Y_MAX) begin
                        dy_n = 1'b0;
                    end
                    if (!dx_q) begin
                        if (xpos_q == X_LHIT && ovl_l) begin
                            dx_n = 1'b1;
                            hit  = 1'b1;
                        end else if (xpos_q == '0) begin
                            miss      = 1'b1;
                            score_r_d = 1'b1;
                        end
                    end else begin
                        if (xpos_q == X_RHIT && ovl_r) begin
                            dx_n = 1'b0;
                            hit  = 1'b1;
                        end else if (xpos_q == X_MAX) begin
                            miss      = 1'b1;
                            score_l_d = 1'b1;
                        end
                    end
                    dx_d = dx_n;
                    dy_d = dy_n;
                    if (miss) begin
                        state_d    = S_IDLE;
                        xpos_d     = X_MID;
                        ypos_d     = park_y;
                        interval_d = INTERVAL_START;
                        speed_d    = '0;
                    end else begin
                        xpos_d = dx_n ? xpos_q + 12'd1 : xpos_q - 12'd1;
                        ypos_d = dy_n ? ypos_q + 12'd1 : ypos_q - 12'd1;
                        if (hit) begin
                            interval_d = (ival_dec < INTERVAL_MIN) ? INTERVAL_MIN : ival_dec;
                            speed_d    = (speed_q == 4'd15) ? speed_q : speed_q + 4'd1;
                        end
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                xpos_d     = X_MID;
                ypos_d     = park_y;
                count_d    = '0;
                interval_d = INTERVAL_START;
                speed_d    = '0;
                if (serve && !abort) begin
                    state_d = S_MOVING;
                    dx_d    = serve_dir;
                    dy_d    = 1'b0;
                end
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            xpos_q     <= X_MID;
            ypos_q     <= '0;
            dx_q       <= 1'b0;
            dy_q       <= 1'b0;
            count_q    <= '0;
            interval_q <= INTERVAL_START;
            speed_q    <= '0;
            score_l_q  <= 1'b0;
            score_r_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            count_q    <= count_d;
            interval_q <= interval_d;
            speed_q    <= speed_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
        end
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign moving      = (state_q == S_MOVING);
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign speed_level = speed_q;

endmodule

// File: tb/tb_pong_ball_motion.sv
// Bench for pong_ball_motion: directed scenarios plus random play,
// every cycle compared against a velocity-based reference model.
module tb_pong_ball_motion;

    localparam int W = 64, H = 48, B = 4, PW = 2, PH = 8;
    localparam int PLX = 2, PRX = 60, IST = 3, IMIN = 1, SH = 1;
    localparam int XMID = (W - B) / 2, XMAX = W - B, YMAX = H - B;

    logic        pclk = 1'b0;
    logic        rst = 1'b1, serve = 1'b0, serve_dir = 1'b0, abort = 1'b0;
    logic [11:0] serve_ypos = '0, pad_l_ypos = '0, pad_r_ypos = '0;
    logic [11:0] xpos, ypos;
    logic        moving, score_l, score_r;
    logic [3:0]  speed_level;

    int n_chk = 0, n_err = 0;
    int m_on, m_x, m_y, m_vx, m_vy, m_cnt, m_int, m_lvl, m_sl, m_sr;
    bit track = 1'b0;

    pong_ball_motion #(
        .SCREEN_W(W), .SCREEN_H(H), .BALL_SIZE(B), .PAD_W(PW), .PAD_H(PH),
        .PAD_L_X(PLX), .PAD_R_X(PRX), .INTERVAL_START(20'd3),
        .INTERVAL_MIN(20'd1), .SPEED_SHIFT(SH)
    ) dut (
        .pclk(pclk), .rst(rst), .serve(serve), .serve_dir(serve_dir),
        .serve_ypos(serve_ypos), .abort(abort), .pad_l_ypos(pad_l_ypos),
        .pad_r_ypos(pad_r_ypos), .xpos(xpos), .ypos(ypos), .moving(moving),
        .score_l(score_l), .score_r(score_r), .speed_level(speed_level)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic park();
        m_x   = XMID;
        m_y   = (int'(serve_ypos) > YMAX) ? YMAX : int'(serve_ypos);
        m_cnt = 0;
        m_int = IST;
        m_lvl = 0;
    endtask

    // Reference: ball as position plus +/-1 velocities, one call per clock edge
    task automatic model_edge();
        int pad, hit_x, wall_x, d;
        bit ovl, hit, miss;
        m_sl = 0;
        m_sr = 0;
        if (rst) begin
            m_on = 0; m_x = XMID; m_y = 0; m_vx = -1; m_vy = -1;
            m_cnt = 0; m_int = IST; m_lvl = 0;
        end else if (!m_on) begin
            park();
            if (serve && !abort) begin
                m_on = 1;
                m_vx = serve_dir ? 1 : -1;
                m_vy = -1;
            end
        end else if (abort) begin
            m_on = 0;
        end else if (m_cnt < m_int) begin
            m_cnt++;
        end else begin
            m_cnt = 0;
            if (m_vy < 0 && m_y == 0) m_vy = 1;
            else if (m_vy > 0 && m_y == YMAX) m_vy = -1;
            pad    = (m_vx < 0) ? int'(pad_l_ypos) : int'(pad_r_ypos);
            hit_x  = (m_vx < 0) ? PLX + PW : PRX - B;
            wall_x = (m_vx < 0) ? 0 : XMAX;
            ovl    = (m_y + B > pad) && (m_y < pad + PH);
            hit    = (m_x == hit_x) && ovl;
            miss   = !hit && (m_x == wall_x);
            if (miss) begin
                if (m_vx < 0) m_sr = 1;
                else m_sl = 1;
                m_on = 0;
                park();
            end else begin
                if (hit) begin
                    m_vx = -m_vx;
                    d = m_int - (m_int >> SH);
                    m_int = (d < IMIN) ? IMIN : d;
                    if (m_lvl < 15) m_lvl++;
                end
                m_x += m_vx;
                m_y += m_vy;
            end
        end
    endtask

    task automatic cyc();
        if (track) begin
            pad_l_ypos = 12'(m_y);
            pad_r_ypos = 12'(m_y);
        end
        @(posedge pclk);
        model_edge();
        #1;
        check("xpos", xpos, m_x);
        check("ypos", ypos, m_y);
        check("moving", moving, m_on);
        check("score_l", score_l, m_sl);
        check("score_r", score_r, m_sr);
        check("speed_level", speed_level, m_lvl);
    endtask

    task automatic do_serve(input logic dir, input logic [11:0] y);
        serve = 1'b1; serve_dir = dir; serve_ypos = y;
        cyc();
        serve = 1'b0;
    endtask

    initial begin
        int n, px;
        // reset and idle tracking
        repeat (3) cyc();
        check("rst_xpos", xpos, 30);
        check("rst_ypos", ypos, 0);
        check("rst_moving", moving, 0);
        rst = 1'b0;
        serve_ypos = 12'd60;
        cyc();
        check("idle_clamp", ypos, 44);
        serve_ypos = 12'd20;
        cyc();
        check("idle_track", ypos, 20);

        // serve right, step timing, abort on a tick
        pad_l_ypos = 12'd40; pad_r_ypos = 12'd40;
        do_serve(1'b1, 12'd20);
        check("serve_moving", moving, 1);
        repeat (3) cyc();
        check("pre_step_x", xpos, 30);
        cyc();
        check("step1_x", xpos, 31);
        check("step1_y", ypos, 19);
        repeat (3) cyc();
        check("hold_x", xpos, 31);
        cyc();
        check("step2_x", xpos, 32);
        repeat (3) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_moving", moving, 0);
        check("abort_nostep", xpos, 32);
        check("abort_noscore", {score_l, score_r}, 0);
        cyc();
        check("abort_park", xpos, 30);

        // top wall bounce
        do_serve(1'b1, 12'd1);
        repeat (4) cyc();
        check("top_y0", ypos, 0);
        repeat (4) cyc();
        check("top_y1", ypos, 1);
        check("top_x", xpos, 32);
        abort = 1'b1; cyc(); abort = 1'b0; cyc();

        // left paddle hit and speed-up
        pad_l_ypos = 12'd8; pad_r_ypos = 12'd0;
        do_serve(1'b0, 12'd36);
        n = 0;
        while (m_lvl == 0 && n < 300) begin cyc(); n++; end
        check("lhit_bound", n < 300, 1);
        check("lhit_x", xpos, 5);
        check("lhit_y", ypos, 9);
        check("lhit_lvl", speed_level, 1);
        repeat (2) cyc();
        check("lhit_hold", xpos, 5);
        cyc();
        check("lhit_period2", xpos, 6);
        track = 1'b1;
        n = 0;
        while (m_lvl < 15 && n < 6000) begin cyc(); n++; end
        check("sat_bound", n < 6000, 1);
        check("sat_lvl", speed_level, 15);
        repeat (300) cyc();
        check("sat_hold", speed_level, 15);
        px = xpos; n = 0;
        while (xpos == 12'(px) && n < 10) begin cyc(); n++; end
        px = xpos; n = 0;
        while (xpos == 12'(px) && n < 10) begin cyc(); n++; end
        check("period_min", n, 2);
        track = 1'b0;
        abort = 1'b1; cyc(); abort = 1'b0; cyc();

        // left miss
        pad_l_ypos = 12'd30;
        do_serve(1'b0, 12'd20);
        n = 0;
        while (m_sr == 0 && n < 400) begin cyc(); n++; end
        check("lmiss_bound", n < 400, 1);
        check("lmiss_score_r", score_r, 1);
        check("lmiss_score_l", score_l, 0);
        check("lmiss_moving", moving, 0);
        check("lmiss_x", xpos, 30);
        cyc();
        check("lmiss_pulse", score_r, 0);

        // right miss
        pad_r_ypos = 12'd30;
        do_serve(1'b1, 12'd20);
        n = 0;
        while (m_sl == 0 && n < 400) begin cyc(); n++; end
        check("rmiss_bound", n < 400, 1);
        check("rmiss_score_l", score_l, 1);
        check("rmiss_score_r", score_r, 0);
        cyc();
        check("rmiss_pulse", score_l, 0);

        // reset mid-flight
        do_serve(1'b1, 12'd10);
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("mrst_x", xpos, 30);
        check("mrst_y", ypos, 0);
        check("mrst_moving", moving, 0);
        check("mrst_score", {score_l, score_r}, 0);

        // random play
        for (int i = 0; i < 4000; i++) begin
            if (i % 256 == 0) track = $urandom_range(0, 1) == 1;
            serve      = $urandom_range(0, 15) == 0;
            serve_dir  = $urandom_range(0, 1) == 1;
            serve_ypos = 12'($urandom_range(0, 63));
            abort      = $urandom_range(0, 299) == 0;
            rst        = $urandom_range(0, 1999) == 0;
            if (!track && $urandom_range(0, 7) == 0) begin
                pad_l_ypos = 12'($urandom_range(0, 63));
                pad_r_ypos = 12'($urandom_range(0, 63));
            end
            cyc();
        end
        serve = 1'b0; abort = 1'b0; rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
